// File: rtl/lzw_out_buffer.sv
// -----------------------------------------------------------------------------
// lzw_out_buffer
//
// Purpose:
//   Responder side of the controller's output-buffer interface. Accepts LZW
//   codes from the microprogrammed controller and packs them LSB-first into a
//   byte stream with a valid/ready handshake. On CloseBuffer any remaining bits
//   are emitted as a zero-padded final byte, after which BufferDone is raised.
//
// Ports:
//   clk              in   system clock, all state changes on posedge
//   reset            in   synchronous, active-high
//   RequestOutBuffer in   push Code this cycle (one code per high cycle)
//   CloseBuffer      in   end of stream: flush and finish
//   Code             in   [CODE_W-1:0] code to append
//   OutData          out  [7:0] output byte
//   OutValid         out  OutData valid
//   OutReady         in   downstream accepts OutData when OutValid && OutReady
//   BufferBusy       out  controller must not push or close while high
//   BufferDone       out  stream fully emitted, sticky until reset
//   Overflow         out  sticky: a push or close was dropped
//   ByteCount        out  [CNT_W-1:0] completed handshakes, wraps
// -----------------------------------------------------------------------------
module lzw_out_buffer #(
    parameter int CODE_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RequestOutBuffer,
    input  logic              CloseBuffer,
    input  logic [CODE_W-1:0] Code,
    output logic [7:0]        OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              BufferBusy,
    output logic              BufferDone,
    output logic              Overflow,
    output logic [CNT_W-1:0]  ByteCount
);

    // A push only lands when fewer than 8 bits are pending, so the worst case
    // is 7 leftover bits plus one full code.
    localparam int ACC_W = CODE_W + 7;
    localparam int CW    = $clog2(CODE_W + 8);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d;

    logic busy;
    logic out_free;
    logic handshake;
    logic have_byte;

    assign have_byte = (cnt_q >= CW'(8));
    assign busy      = have_byte || (state_q != ST_RUN);
    assign out_free  = !valid_q || OutReady;
    assign handshake = valid_q && OutReady;

    assign OutData    = data_q;
    assign OutValid   = valid_q;
    assign BufferBusy = busy;
    assign BufferDone = done_q;
    assign Overflow   = ovf_q;
    assign ByteCount  = bcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        bcnt_d  = bcnt_q;

        if (handshake) begin
            bcnt_d = bcnt_q + CNT_W'(1);
        end

        // Any request arriving while busy is lost; flag it for the controller.
        if ((RequestOutBuffer || CloseBuffer) && busy) begin
            ovf_d = 1'b1;
        end

        // Bits above cnt are always zero, so OR-ing the shifted code appends it.
        if (RequestOutBuffer && !busy) begin
            acc_d = acc_q | (ACC_W'(Code) << cnt_q);
            cnt_d = cnt_q + CW'(CODE_W);
        end

        // A same-cycle push has already been folded in above, so entering
        // FLUSH here flushes that code too.
        if (CloseBuffer && !busy) begin
            state_d = ST_FLUSH;
        end

        // Push requires cnt<8 and RUN; every branch below requires cnt>=8 or
        // FLUSH, so none of them can overwrite a push.
        if (have_byte && out_free) begin
            data_d  = acc_q[7:0];
            acc_d   = acc_q >> 8;
            cnt_d   = cnt_q - CW'(8);
            valid_d = 1'b1;
        end else if (state_q == ST_FLUSH && cnt_q != '0 && out_free) begin
            // Partial final byte: bits above cnt are already zero.
            data_d  = acc_q[7:0];
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (state_q == ST_FLUSH && out_free) begin
            // cnt is zero and the last byte is gone (or leaving this edge).
            state_d = ST_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

endmodule
